// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: predictor update record and resolve FSM states.
package branch_resolve_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
  } br_update_t;

  typedef enum logic [1:0] {
    BRR_IDLE,
    BRR_FLUSH,
    BRR_DRAIN
  } brr_state_t;

  // Sequential fetch PC after a branch; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] fallthrough_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/br_update_fifo.sv
// Small FIFO of predictor training records; extra pointer MSB distinguishes full from empty.
module br_update_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  br_update_t data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output br_update_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  br_update_t  mem_q [DEPTH];
  logic        push_en;
  logic        pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is only observed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves committed branches: trains the predictor via a FIFO, flushes and redirects on a
// direction mispredict, blocks commits while the pipeline drains, and counts branches.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_commit_valid,
  output logic             br_commit_ready,
  input  logic [31:0]      br_commit_pc,
  input  logic             br_commit_taken,
  input  logic             br_commit_pred,
  input  logic [31:0]      br_commit_target,
  output logic             pc_result_load,
  output logic [31:0]      pc_result,
  output logic             br_result,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned DrainW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [DrainW-1:0] DrainInit =
      DrainW'((FLUSH_CYCLES >= 2) ? (FLUSH_CYCLES - 2) : 0);

  brr_state_t        state_q;
  logic [DrainW-1:0] drain_q;
  logic              flush_q;
  logic [31:0]       redirect_q;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  misp_cnt_q, misp_cnt_d;

  logic       fifo_full;
  logic       fifo_empty;
  br_update_t fifo_head;
  br_update_t fifo_in;
  logic       accept;
  logic       mispredict;

  // Ready depends only on registered state, so a full FIFO blocks even if it pops this cycle.
  assign br_commit_ready = (state_q == BRR_IDLE) && !fifo_full;
  assign accept          = br_commit_valid && br_commit_ready;
  assign mispredict      = accept && (br_commit_taken != br_commit_pred);

  assign fifo_in.pc    = br_commit_pc;
  assign fifo_in.taken = br_commit_taken;

  br_update_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (fifo_in),
    .pop_i   (!fifo_empty),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign pc_result_load = !fifo_empty;
  assign pc_result      = fifo_empty ? 32'h0 : fifo_head.pc;
  assign br_result      = fifo_empty ? 1'b0 : fifo_head.taken;

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BRR_IDLE;
      drain_q    <= '0;
      flush_q    <= 1'b0;
      redirect_q <= 32'h0;
    end else begin
      unique case (state_q)
        BRR_IDLE: begin
          flush_q <= 1'b0;
          if (mispredict) begin
            state_q    <= BRR_FLUSH;
            flush_q    <= 1'b1;
            redirect_q <= br_commit_taken ? br_commit_target : fallthrough_pc(br_commit_pc);
          end
        end
        BRR_FLUSH: begin
          flush_q <= 1'b0;
          if (FLUSH_CYCLES <= 1) begin
            state_q <= BRR_IDLE;
          end else begin
            state_q <= BRR_DRAIN;
            drain_q <= DrainInit;
          end
        end
        BRR_DRAIN: begin
          flush_q <= 1'b0;
          if (drain_q == '0) state_q <= BRR_IDLE;
          else               drain_q <= drain_q - DrainW'(1);
        end
        default: begin
          state_q <= BRR_IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (accept)     branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (mispredict) misp_cnt_d   = misp_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = misp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed commits, monitor checks updates/flushes.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_commit_valid;
  logic        br_commit_ready;
  logic [31:0] br_commit_pc;
  logic        br_commit_taken;
  logic        br_commit_pred;
  logic [31:0] br_commit_target;
  logic        pc_result_load;
  logic [31:0] pc_result;
  logic        br_result;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  // Narrow-counter instance to exercise counter wrap.
  logic        s_valid;
  logic        s_ready;
  logic        s_load;
  logic [31:0] s_pc_result;
  logic        s_br_result;
  logic        s_flush;
  logic [31:0] s_redirect;
  logic [1:0]  s_branch_count;
  logic [1:0]  s_misp_count;

  int checks = 0;
  int fails  = 0;

  br_update_t  exp_q[$];
  logic [31:0] redir_q[$];
  logic [31:0] br_m   = 32'h0;
  logic [31:0] misp_m = 32'h0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .DEPTH        (4),
    .FLUSH_CYCLES (2),
    .CNT_W        (32)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .br_commit_valid  (br_commit_valid),
    .br_commit_ready  (br_commit_ready),
    .br_commit_pc     (br_commit_pc),
    .br_commit_taken  (br_commit_taken),
    .br_commit_pred   (br_commit_pred),
    .br_commit_target (br_commit_target),
    .pc_result_load   (pc_result_load),
    .pc_result        (pc_result),
    .br_result        (br_result),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  branch_resolve_unit #(
    .DEPTH        (4),
    .FLUSH_CYCLES (2),
    .CNT_W        (2)
  ) u_small (
    .clk              (clk),
    .rst              (rst),
    .br_commit_valid  (s_valid),
    .br_commit_ready  (s_ready),
    .br_commit_pc     (32'hFFFF_FFFC),
    .br_commit_taken  (1'b0),
    .br_commit_pred   (1'b1),
    .br_commit_target (32'h0000_1234),
    .pc_result_load   (s_load),
    .pc_result        (s_pc_result),
    .br_result        (s_br_result),
    .flush            (s_flush),
    .redirect_pc      (s_redirect),
    .branch_count     (s_branch_count),
    .mispredict_count (s_misp_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented update / flush against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (pc_result_load) begin
        if (exp_q.size() == 0) begin
          check("unexpected update", {32'h0, pc_result}, 64'hDEAD);
        end else begin
          br_update_t e;
          e = exp_q.pop_front();
          check("update pc", {32'h0, pc_result}, {32'h0, e.pc});
          check("update taken", {63'h0, br_result}, {63'h0, e.taken});
        end
      end
      if (flush) begin
        if (redir_q.size() == 0) begin
          check("unexpected flush", {32'h0, redirect_pc}, 64'hDEAD);
        end else begin
          logic [31:0] r;
          r = redir_q.pop_front();
          check("redirect_pc", {32'h0, redirect_pc}, {32'h0, r});
        end
      end
      check("branch_count", {32'h0, branch_count}, {32'h0, br_m});
      check("mispredict_count", {32'h0, mispredict_count}, {32'h0, misp_m});
    end
  end

  // Drives one commit and waits (bounded) for it to be accepted; inputs change at posedge+1.
  task automatic commit(input logic [31:0] pc, input logic taken, input logic pred,
                        input logic [31:0] tgt, input bit must_be_ready);
    int waited;
    waited           = 0;
    br_commit_valid  = 1'b1;
    br_commit_pc     = pc;
    br_commit_taken  = taken;
    br_commit_pred   = pred;
    br_commit_target = tgt;
    @(negedge clk);
    if (must_be_ready) check("ready during burst", {63'h0, br_commit_ready}, 64'h1);
    while (!br_commit_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!br_commit_ready) begin
      check("commit accept timeout", 64'h0, 64'h1);
      br_commit_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back('{pc: pc, taken: taken});
      if (taken != pred) begin
        redir_q.push_back(taken ? tgt : pc + 32'd4);
        misp_m = misp_m + 32'd1;
      end
      br_m = br_m + 32'd1;
      #1;
      br_commit_valid = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    br_commit_valid  = 1'b0;
    br_commit_pc     = 32'h0;
    br_commit_taken  = 1'b0;
    br_commit_pred   = 1'b0;
    br_commit_target = 32'h0;
    s_valid          = 1'b0;
    idle_cycles(2);
    check("reset load", {63'h0, pc_result_load}, 64'h0);
    check("reset flush", {63'h0, flush}, 64'h0);
    check("reset pc_result", {32'h0, pc_result}, 64'h0);
    check("reset redirect", {32'h0, redirect_pc}, 64'h0);
    check("reset branch_count", {32'h0, branch_count}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", {63'h0, br_commit_ready}, 64'h1);
    @(posedge clk); #1;

    // Correct prediction: update appears next cycle, no flush.
    commit(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    check("first update latency", {63'h0, pc_result_load}, 64'h1);
    check("no flush on hit", {63'h0, flush}, 64'h0);
    idle_cycles(2);

    // Not-taken mispredict: redirect to pc+4, commits blocked for two cycles.
    commit(32'h0000_0200, 1'b0, 1'b1, 32'h0000_0900, 1'b0);
    check("flush after mispredict", {63'h0, flush}, 64'h1);
    @(negedge clk);
    check("ready low in flush", {63'h0, br_commit_ready}, 64'h0);
    @(negedge clk);
    check("ready low in drain", {63'h0, br_commit_ready}, 64'h0);
    @(negedge clk);
    check("ready back in idle", {63'h0, br_commit_ready}, 64'h1);
    @(posedge clk); #1;

    // Taken mispredict: redirect to target, still trains taken.
    commit(32'h0000_0300, 1'b1, 1'b0, 32'h0000_0080, 1'b0);
    idle_cycles(4);

    // Target differs but direction right: not a mispredict.
    commit(32'h0000_0600, 1'b1, 1'b1, 32'h0000_0ABC, 1'b0);
    idle_cycles(2);

    // Burst of 6 back-to-back commits.
    for (int i = 0; i < 6; i++) begin
      commit(32'h0000_1000 + 32'(i * 4), 1'(i % 2), 1'(i % 2), 32'h0, 1'b1);
      br_commit_valid = 1'b1;
    end
    br_commit_valid = 1'b0;
    idle_cycles(3);

    // Fall-through wraps at the top of the address space.
    commit(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0010, 1'b0);
    idle_cycles(4);

    // Reset in the middle of DRAIN.
    commit(32'h0000_0400, 1'b1, 1'b0, 32'h0000_0500, 1'b0);
    @(posedge clk); #1;
    check("ready low before reset", {63'h0, br_commit_ready}, 64'h0);
    rst = 1'b1;
    #1;
    check("rst flush", {63'h0, flush}, 64'h0);
    check("rst load", {63'h0, pc_result_load}, 64'h0);
    check("rst branch_count", {32'h0, branch_count}, 64'h0);
    check("rst mispredict_count", {32'h0, mispredict_count}, 64'h0);
    exp_q.delete();
    redir_q.delete();
    br_m   = 32'h0;
    misp_m = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready after mid-drain reset", {63'h0, br_commit_ready}, 64'h1);
    @(posedge clk); #1;
    commit(32'h0000_0700, 1'b0, 1'b0, 32'h0, 1'b0);
    idle_cycles(2);

    // Narrow counters wrap modulo 4 after four mispredicts.
    for (int k = 1; k <= 4; k++) begin
      int waited;
      waited  = 0;
      s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("small ready", {63'h0, s_ready}, 64'h1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      check("small flush", {63'h0, s_flush}, 64'h1);
      check("small redirect wrap", {32'h0, s_redirect}, 64'h0);
      check("small mispredict_count", {62'h0, s_misp_count}, 64'(k % 4));
      check("small branch_count", {62'h0, s_branch_count}, 64'(k % 4));
    end
    idle_cycles(4);

    check("scoreboard updates drained", 64'(exp_q.size()), 64'h0);
    check("scoreboard flushes drained", 64'(redir_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
